// File: rtl/ps2_keyboard_rx_if.sv
// Key-event stream from the PS/2 receiver to the keyboard matrix logic.
// valid/ready: the source holds code/ext/release stable while valid is high and
// ready is low; an event transfers on any rising clk edge with valid && ready.
interface ps2_keyboard_rx_if;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;

   modport master (
      output key_valid, key_code, key_ext, key_release,
      input  key_ready
   );

   modport slave (
      input  key_valid, key_code, key_ext, key_release,
      output key_ready
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: oversampled frame deserializer, E0/F0 prefix decode,
// and a first-word fall-through event FIFO toward the core.
module ps2_keyboard_rx #(
   parameter int TIMEOUT = 4095,
   parameter int FIFO_AW = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ps2_clk,
   input  logic                      ps2_data,
   ps2_keyboard_rx_if.master         key,
   output logic                      parity_err,
   output logic                      frame_err,
   output logic                      overflow,
   output logic                      dbg_state
);

   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t          state, state_n;
   logic            clk_s1, clk_s2, clk_prev;
   logic            dat_s1, dat_s2;
   logic            fall;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [TW-1:0]   to_cnt, to_cnt_n;
   logic [7:0]      shreg, shreg_n;
   logic            par, par_n;
   logic            done_n, perr_n, ferr_n;
   logic            byte_done;
   logic            ext_pend, rel_pend;
   logic            push_req, pop, full, wr_en;
   logic [9:0]      mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;

   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         byte_done  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         to_cnt     <= to_cnt_n;
         shreg      <= shreg_n;
         par        <= par_n;
         byte_done  <= done_n;
         parity_err <= perr_n;
         frame_err  <= ferr_n;
      end
   end

   // bit_cnt 1..8 are data (LSB first), 9 is parity, 10 is stop.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      to_cnt_n  = to_cnt;
      shreg_n   = shreg;
      par_n     = par;
      done_n    = 1'b0;
      perr_n    = 1'b0;
      ferr_n    = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            to_cnt_n  = '0;
            if (fall) begin
               if (!dat_s2) begin
                  state_n   = RECV;
                  bit_cnt_n = 4'd1;
               end else begin
                  ferr_n = 1'b1;
               end
            end
         end
         RECV: begin
            if (fall) begin
               to_cnt_n  = '0;
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt <= 4'd8) begin
                  shreg_n = {dat_s2, shreg[7:1]};
               end else if (bit_cnt == 4'd9) begin
                  par_n = dat_s2;
               end else begin
                  state_n   = IDLE;
                  bit_cnt_n = '0;
                  if (!dat_s2)
                     ferr_n = 1'b1;
                  else if (^{shreg, par} == 1'b0)
                     perr_n = 1'b1;
                  else
                     done_n = 1'b1;
               end
            end else if (to_cnt == TW'(TIMEOUT)) begin
               state_n   = IDLE;
               bit_cnt_n = '0;
               to_cnt_n  = '0;
               ferr_n    = 1'b1;
            end else begin
               to_cnt_n = to_cnt + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign push_req = byte_done && (shreg != 8'hE0) && (shreg != 8'hF0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_pend <= 1'b0;
         rel_pend <= 1'b0;
      end else if (parity_err || frame_err || push_req) begin
         ext_pend <= 1'b0;
         rel_pend <= 1'b0;
      end else if (byte_done) begin
         if (shreg == 8'hE0) ext_pend <= 1'b1;
         if (shreg == 8'hF0) rel_pend <= 1'b1;
      end
   end

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign pop   = key.key_valid && key.key_ready;
   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign wr_en = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {ext_pend, rel_pend, shreg};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
         count    <= count + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);
         overflow <= push_req && full && !pop;
      end
   end

   assign key.key_valid   = (count != '0);
   assign key.key_code    = key.key_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign key.key_release = key.key_valid ? mem[rd_ptr][8]   : 1'b0;
   assign key.key_ext     = key.key_valid ? mem[rd_ptr][9]   : 1'b0;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Downstream consumer of the ps2_clk/ps2_data pair produced by the MiST SPI user-io block.
- Runs on the core system clock. Oversamples the PS/2 lines and deserializes 11-bit frames.
- Decodes the E0 (extended) and F0 (release) prefixes into one key event per make/break code.
- Buffers events in a small FIFO with a valid/ready handshake toward the core's keyboard matrix logic.

Parameters:
- TIMEOUT, 4095: clk cycles allowed between consecutive ps2_clk falling edges inside a frame before the frame is aborted.
- FIFO_AW, 2: log2 of event FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock from upstream; idles high; asynchronous to clk.
- ps2_data  in  1  PS/2 data from upstream; asynchronous to clk.
- key_valid  out  1  FIFO head holds an event.
- key_ready  in  1  consumer accepts the head event when key_valid and key_ready are both high at a clk edge.
- key_code  out  8  scancode of the head event.
- key_ext  out  1  head event was preceded by E0.
- key_release  out  1  head event was preceded by F0.
- parity_err  out  1  one-cycle pulse: frame received with bad parity.
- frame_err  out  1  one-cycle pulse: start bit ≠ 0, stop bit ≠ 1, or timeout.
- overflow  out  1  one-cycle pulse: event dropped because the FIFO was full.

Behaviour:
- Reset (async, while reset_n is low):
  - Sync flops = 1. State IDLE. bit_cnt = 0. Timeout counter = 0.
  - ext_pend = 0, rel_pend = 0. FIFO empty.
  - key_valid = 0, key_code = 0, key_ext = 0, key_release = 0.
  - All error pulses = 0.
  - Reset asserted mid-frame discards the partial frame and pending prefixes.
- Sync and sampling:
  - ps2_clk and ps2_data each pass through 2 flops.
  - fall = prev_sync_clk & ~sync_clk.
  - Data is sampled from sync_data in the cycle fall is high.
- Frame FSM:
  - IDLE: on fall:
    - sync_data = 0 → RECV, bit_cnt = 1, timeout counter cleared.
    - sync_data = 1 → pulse frame_err, stay IDLE.
  - RECV, bit_cnt 1..8: shift data in LSB first.
  - RECV, bit_cnt 9: capture parity bit.
  - RECV, bit_cnt 10: capture stop bit and go to IDLE. Then check:
    - stop = 0 → frame_err.
    - otherwise, XOR(data[7:0], parity) = 0 → parity_err.
    - otherwise → byte_done pulse carrying the byte.
  - Each fall in RECV increments bit_cnt and clears the timeout counter.
  - Timeout counter increments every clk in RECV. When it reaches TIMEOUT: pulse frame_err, go to IDLE, discard the frame.
- Decode (in the cycle after byte_done):
  - E0 → ext_pend = 1, no event.
  - F0 → rel_pend = 1, no event.
  - Any other byte (including AA, FA, FE) → push {ext_pend, rel_pend, byte}, then clear both pends.
  - Any parity_err or frame_err clears both pends.
- FIFO:
  - First-word fall-through; depth 2^FIFO_AW; wrapping read/write pointers plus a count.
  - key_valid = count ≠ 0. key_code, key_ext and key_release show the head entry.
  - Head outputs are held stable while key_valid is high and key_ready is low.
  - Pop on key_valid & key_ready.
  - Push when full: accepted if a pop occurs in the same cycle (count unchanged). Otherwise the event is dropped, overflow pulses, and the pends are still cleared.
  - Push and pop when not full: count unchanged.
- Latency: key_valid rises exactly 4 clk rising edges after the ps2_clk pin falls for the stop bit, provided the FIFO was empty. The 4 edges are sync1, sync2, stop capture, FIFO write.
- Upstream compatibility: upstream ps2_clk low phases last one upstream clk period. The receiver requires ps2_clk low and high phases of ≥3 clk cycles each.

Test Plan:
- Frame 0x1C with odd parity=0, stop=1, key_ready=1:
  - one event: key_code=0x1C, ext=0, release=0, key_valid high for exactly 1 cycle;
  - rises 4 clks after the stop-bit edge.
- Frames E0, F0, 0x75 back-to-back:
  - exactly one event: 0x75, ext=1, release=1;
  - next frame 0x75 gives ext=0, release=0 (prefixes cleared).
- Frame 0x1C with parity bit=1:
  - parity_err pulses once, no event.
  - Sequence F0 then bad frame then 0x1C: 0x1C arrives with release=0.
- Stop after 5 bits with ps2_clk held high for TIMEOUT+10 cycles, then a good 0x29 frame:
  - frame_err pulses once;
  - event 0x29 follows with no corruption.
- key_ready=0, send 5 frames 0x01..0x05:
  - FIFO holds 01..04, overflow pulses once on 05;
  - then key_ready=1 drains 01,02,03,04 in order, one per cycle.
- Assert reset_n low mid-frame (after bit 4) for 2 clks, then send a full 0x5A frame:
  - all outputs at reset values during reset;
  - single event 0x5A after release.
